// File: rtl/mips_multicycle_seq.sv
// rtl/mips_multicycle_seq.sv - multicycle MIPS sequencer: PC, FSM, decode and next-PC
module mips_multicycle_seq #(
    parameter int                unsigned PC_W = 32,
    parameter logic [PC_W-1:0]   RESET_PC = 128,
    parameter int                unsigned MAX_INSTR = 0,
    parameter int                unsigned CNT_W = 16,
    parameter int                unsigned HALT_ON_ILLEGAL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ins,
    input  logic              zero,
    output logic [PC_W-1:0]   pc,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              ALUSrc,
    output logic [2:0]        op,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemToReg,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            state, state_next;
    logic [31:0]       ir;
    logic              zflag;

    logic              lv_regdst, lv_regwrite, lv_alusrc;
    logic [2:0]        lv_op;
    logic              lv_memread, lv_memwrite, lv_memtoreg;

    logic              d_legal;
    logic              d_regdst, d_regwrite, d_alusrc;
    logic [2:0]        d_op;
    logic              d_memread, d_memwrite, d_memtoreg;

    logic [PC_W-1:0]   pcp4, br_off, next_pc;
    logic [CNT_W-1:0]  retired_inc;
    logic              max_hit;
    logic              levels_on;

    always_comb begin
        d_legal    = 1'b1;
        d_regdst   = 1'b0;
        d_regwrite = 1'b0;
        d_alusrc   = 1'b0;
        d_op       = 3'd0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_memtoreg = 1'b0;
        case (ir[31:26])
            6'h00: begin
                d_regdst   = 1'b1;
                d_regwrite = 1'b1;
                case (ir[5:0])
                    6'h20:   d_op = 3'd2;
                    6'h22:   d_op = 3'd6;
                    6'h24:   d_op = 3'd0;
                    6'h25:   d_op = 3'd1;
                    6'h2A:   d_op = 3'd7;
                    default: d_legal = 1'b0;
                endcase
            end
            6'h08: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
                d_op       = 3'd2;
            end
            6'h23: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
                d_op       = 3'd2;
                d_memread  = 1'b1;
                d_memtoreg = 1'b1;
            end
            6'h2B: begin
                d_alusrc   = 1'b1;
                d_op       = 3'd2;
                d_memwrite = 1'b1;
            end
            6'h04:   d_op = 3'd6;
            6'h02:   d_op = 3'd2;
            default: d_legal = 1'b0;
        endcase
        // Illegal words decode to a NOP so nothing leaks out when execution continues.
        if (!d_legal) begin
            d_regdst   = 1'b0;
            d_regwrite = 1'b0;
            d_alusrc   = 1'b0;
            d_op       = 3'd0;
            d_memread  = 1'b0;
            d_memwrite = 1'b0;
            d_memtoreg = 1'b0;
        end
    end

    always_comb begin
        pcp4   = pc + PC_W'(4);
        br_off = {{(PC_W-18){ir[15]}}, ir[15:0], 2'b00};
        next_pc = pcp4;
        if (ir[31:26] == 6'h04 && zflag) begin
            next_pc = pcp4 + br_off;
        end else if (ir[31:26] == 6'h02) begin
            next_pc        = pcp4;
            next_pc[27:0]  = {ir[25:0], 2'b00};
        end
        retired_inc = (&retired) ? retired : retired + CNT_W'(1);
        max_hit     = (MAX_INSTR != 0) && (retired_inc == CNT_W'(MAX_INSTR));
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = (!d_legal && HALT_ON_ILLEGAL != 0) ? S_HALT : S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = max_hit ? S_HALT : S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ir          <= '0;
            zflag       <= 1'b0;
            retired     <= '0;
            illegal     <= 1'b0;
            lv_regdst   <= 1'b0;
            lv_regwrite <= 1'b0;
            lv_alusrc   <= 1'b0;
            lv_op       <= 3'd0;
            lv_memread  <= 1'b0;
            lv_memwrite <= 1'b0;
            lv_memtoreg <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH: ir <= ins;
                S_DECODE: begin
                    lv_regdst   <= d_regdst;
                    lv_regwrite <= d_regwrite;
                    lv_alusrc   <= d_alusrc;
                    lv_op       <= d_op;
                    lv_memread  <= d_memread;
                    lv_memwrite <= d_memwrite;
                    lv_memtoreg <= d_memtoreg;
                    if (!d_legal) begin
                        illegal <= 1'b1;
                    end
                end
                S_EXEC: zflag <= zero;
                S_WB: begin
                    pc      <= next_pc;
                    retired <= retired_inc;
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by state so an async reset clears the strobes in the same timestep.
    always_comb begin
        levels_on = (state == S_EXEC) || (state == S_WB);
        RegDst    = levels_on && lv_regdst;
        ALUSrc    = levels_on && lv_alusrc;
        op        = levels_on ? lv_op : 3'd0;
        MemRead   = levels_on && lv_memread;
        MemToReg  = levels_on && lv_memtoreg;
        RegWrite  = (state == S_WB) && lv_regwrite;
        MemWrite  = (state == S_WB) && lv_memwrite;
        halted    = (state == S_HALT);
    end

endmodule

// File: tb/tb_mips_multicycle_seq.sv
// tb/tb_mips_multicycle_seq.sv - randomized bench for mips_multicycle_seq against an instruction-level model
module tb_mips_multicycle_seq;

    logic        clk;
    logic        reset_v    [2];
    logic [31:0] ins_v      [2];
    logic        zero_v     [2];
    logic [31:0] pc_v       [2];
    logic        regdst_v   [2];
    logic        regwrite_v [2];
    logic        alusrc_v   [2];
    logic [2:0]  op_v       [2];
    logic        memread_v  [2];
    logic        memwrite_v [2];
    logic        memtoreg_v [2];
    logic        halted_v   [2];
    logic        illegal_v  [2];
    logic [15:0] retired_v  [2];

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] m_pc   [2];
    int          m_ret  [2];
    logic        m_ill  [2];
    logic        m_halt [2];

    mips_multicycle_seq #(.PC_W(32), .RESET_PC(32'd128), .MAX_INSTR(0), .CNT_W(16), .HALT_ON_ILLEGAL(1)) dut0 (
        .clk(clk), .reset(reset_v[0]), .ins(ins_v[0]), .zero(zero_v[0]), .pc(pc_v[0]),
        .RegDst(regdst_v[0]), .RegWrite(regwrite_v[0]), .ALUSrc(alusrc_v[0]), .op(op_v[0]),
        .MemRead(memread_v[0]), .MemWrite(memwrite_v[0]), .MemToReg(memtoreg_v[0]),
        .halted(halted_v[0]), .illegal(illegal_v[0]), .retired(retired_v[0])
    );

    mips_multicycle_seq #(.PC_W(32), .RESET_PC(32'd128), .MAX_INSTR(11), .CNT_W(16), .HALT_ON_ILLEGAL(0)) dut1 (
        .clk(clk), .reset(reset_v[1]), .ins(ins_v[1]), .zero(zero_v[1]), .pc(pc_v[1]),
        .RegDst(regdst_v[1]), .RegWrite(regwrite_v[1]), .ALUSrc(alusrc_v[1]), .op(op_v[1]),
        .MemRead(memread_v[1]), .MemWrite(memwrite_v[1]), .MemToReg(memtoreg_v[1]),
        .halted(halted_v[1]), .illegal(illegal_v[1]), .retired(retired_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] obs(input int d);
        return {regdst_v[d], regwrite_v[d], alusrc_v[d], op_v[d], memread_v[d], memwrite_v[d], memtoreg_v[d]};
    endfunction

    function automatic logic [8:0] mk(input bit rd, input bit rw, input bit as, input logic [2:0] o,
                                      input bit mr, input bit mw, input bit mt);
        return {rd, rw, as, o, mr, mw, mt};
    endfunction

    // Instruction-level reference: control word {RegDst,RegWrite,ALUSrc,op,MemRead,MemWrite,MemToReg}
    function automatic logic [8:0] exp_dec(input logic [31:0] w, output logic legal);
        legal = 1'b1;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20: return mk(1, 1, 0, 3'd2, 0, 0, 0);
                6'h22: return mk(1, 1, 0, 3'd6, 0, 0, 0);
                6'h24: return mk(1, 1, 0, 3'd0, 0, 0, 0);
                6'h25: return mk(1, 1, 0, 3'd1, 0, 0, 0);
                6'h2A: return mk(1, 1, 0, 3'd7, 0, 0, 0);
                default: begin legal = 1'b0; return 9'h0; end
            endcase
            6'h08: return mk(0, 1, 1, 3'd2, 0, 0, 0);
            6'h23: return mk(0, 1, 1, 3'd2, 1, 0, 1);
            6'h2B: return mk(0, 0, 1, 3'd2, 0, 1, 0);
            6'h04: return mk(0, 0, 0, 3'd6, 0, 0, 0);
            6'h02: return mk(0, 0, 0, 3'd2, 0, 0, 0);
            default: begin legal = 1'b0; return 9'h0; end
        endcase
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w, input logic z);
        logic [31:0] seq;
        int off;
        seq = p + 32'd4;
        off = $signed(w[15:0]);
        if (w[31:26] == 6'h04 && z) return seq + 32'(off * 4);
        if (w[31:26] == 6'h02) return {seq[31:28], w[25:0], 2'b00};
        return seq;
    endfunction

    function automatic logic [31:0] gen_word(input bit flow);
        logic [31:0] r;
        logic [5:0]  fn [5];
        int k;
        fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        r = $urandom;
        k = flow ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 3));
        case (k)
            0: begin r[31:26] = 6'h00; r[5:0] = fn[$urandom_range(0, 4)]; end
            1: r[31:26] = 6'h08;
            2: r[31:26] = 6'h23;
            3: r[31:26] = 6'h2B;
            4: r[31:26] = 6'h04;
            default: r[31:26] = 6'h02;
        endcase
        return r;
    endfunction

    task automatic model_reset(input int d);
        m_pc[d] = 32'd128; m_ret[d] = 0; m_ill[d] = 1'b0; m_halt[d] = 1'b0;
    endtask

    // Runs one 4-cycle instruction slot starting at a negedge in FETCH; abort_ph asserts reset in that phase.
    task automatic step_instr(input int d, input logic [31:0] w, input logic z, input int abort_ph);
        logic legal, hoi, stops, eh, ei;
        logic [8:0] ctl, e;
        ctl = exp_dec(w, legal);
        hoi = (d == 0);
        stops = !legal && hoi && !m_halt[d];
        for (int ph = 0; ph < 4; ph++) begin
            e  = (m_halt[d] || stops || ph < 2) ? 9'h0 : ((ph == 2) ? (ctl & 9'h17D) : ctl);
            eh = m_halt[d] || (stops && ph >= 2);
            ei = m_ill[d] || (!legal && !m_halt[d] && ph >= 2);
            total_cnt++;
            if (obs(d) !== e) $display("FAIL ctl dut%0d ph%0d ins=%h got %h expected %h", d, ph, w, obs(d), e);
            else pass_cnt++;
            total_cnt++;
            if (pc_v[d] !== m_pc[d]) $display("FAIL pc dut%0d ph%0d got %h expected %h", d, ph, pc_v[d], m_pc[d]);
            else pass_cnt++;
            total_cnt++;
            if (halted_v[d] !== eh) $display("FAIL halted dut%0d ph%0d got %b expected %b", d, ph, halted_v[d], eh);
            else pass_cnt++;
            total_cnt++;
            if (illegal_v[d] !== ei) $display("FAIL illegal dut%0d ph%0d got %b expected %b", d, ph, illegal_v[d], ei);
            else pass_cnt++;
            if (ph == abort_ph) begin
                reset_v[d] = 1'b1;
                #1;
                total_cnt++;
                if (regwrite_v[d] !== 1'b0 || memwrite_v[d] !== 1'b0)
                    $display("FAIL abort_strobes dut%0d got rw=%b mw=%b expected 0", d, regwrite_v[d], memwrite_v[d]);
                else pass_cnt++;
                total_cnt++;
                if (pc_v[d] !== 32'd128 || illegal_v[d] !== 1'b0 || retired_v[d] !== 16'd0 || halted_v[d] !== 1'b0)
                    $display("FAIL abort_state dut%0d got pc=%h ill=%b ret=%0d halt=%b expected 80/0/0/0",
                             d, pc_v[d], illegal_v[d], retired_v[d], halted_v[d]);
                else pass_cnt++;
                model_reset(d);
                return;
            end
            ins_v[d]  = (ph == 0) ? w : $urandom;
            zero_v[d] = (ph == 2) ? z : 1'($urandom);
            @(negedge clk);
        end
        if (!m_halt[d]) begin
            if (stops) begin
                m_halt[d] = 1'b1;
                m_ill[d]  = 1'b1;
            end else begin
                if (!legal) m_ill[d] = 1'b1;
                m_pc[d] = model_next(m_pc[d], w, z);
                if (m_ret[d] < 65535) m_ret[d]++;
                if (d == 1 && m_ret[d] == 11) m_halt[d] = 1'b1;
            end
        end
        total_cnt++;
        if (pc_v[d] !== m_pc[d]) $display("FAIL next_pc dut%0d ins=%h got %h expected %h", d, w, pc_v[d], m_pc[d]);
        else pass_cnt++;
        total_cnt++;
        if (retired_v[d] !== 16'(m_ret[d])) $display("FAIL retired dut%0d got %0d expected %0d", d, retired_v[d], m_ret[d]);
        else pass_cnt++;
        total_cnt++;
        if (halted_v[d] !== m_halt[d]) $display("FAIL halt_after dut%0d got %b expected %b", d, halted_v[d], m_halt[d]);
        else pass_cnt++;
    endtask

    task automatic test_reset(input int d);
        reset_v[d] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (pc_v[d] !== 32'd128 || obs(d) !== 9'h0 || halted_v[d] !== 1'b0 || illegal_v[d] !== 1'b0 || retired_v[d] !== 16'd0)
            $display("FAIL reset dut%0d got pc=%h ctl=%h halt=%b ill=%b ret=%0d expected 80/0/0/0/0",
                     d, pc_v[d], obs(d), halted_v[d], illegal_v[d], retired_v[d]);
        else pass_cnt++;
        reset_v[d] = 1'b0;
        model_reset(d);
    endtask

    task automatic test_addi;
        step_instr(0, 32'h20080005, 1'b0, -1);
        total_cnt++;
        if (pc_v[0] !== 32'd132 || retired_v[0] !== 16'd1)
            $display("FAIL addi_end got pc=%0d ret=%0d expected 132/1", pc_v[0], retired_v[0]);
        else pass_cnt++;
    endtask

    task automatic test_rtype;
        step_instr(0, 32'h01095022, 1'b1, -1);
        step_instr(0, 32'h0109502A, 1'b0, -1);
        step_instr(0, 32'h01095024, 1'b1, -1);
        step_instr(0, 32'h01095025, 1'b0, -1);
    endtask

    task automatic test_j_sw;
        test_reset(0);
        step_instr(0, 32'h08000040, 1'b1, -1);
        total_cnt++;
        if (pc_v[0] !== 32'h100) $display("FAIL j_target got %h expected 100", pc_v[0]);
        else pass_cnt++;
        step_instr(0, 32'hAD090004, 1'b1, -1);
        step_instr(0, 32'h8D090004, 1'b0, -1);
    endtask

    task automatic test_beq;
        step_instr(0, 32'h08000032, 1'b0, -1);
        step_instr(0, 32'h1109FFFE, 1'b1, -1);
        total_cnt++;
        if (pc_v[0] !== 32'd196) $display("FAIL beq_taken got %0d expected 196", pc_v[0]);
        else pass_cnt++;
        step_instr(0, 32'h08000032, 1'b1, -1);
        step_instr(0, 32'h1109FFFE, 1'b0, -1);
        total_cnt++;
        if (pc_v[0] !== 32'd204) $display("FAIL beq_not_taken got %0d expected 204", pc_v[0]);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        step_instr(0, 32'h08000000, 1'b1, -1);
        step_instr(0, 32'h1000FFFE, 1'b1, -1);
        total_cnt++;
        if (pc_v[0] !== 32'hFFFFFFFC) $display("FAIL wrap_top got %h expected fffffffc", pc_v[0]);
        else pass_cnt++;
        step_instr(0, 32'h20080005, 1'b0, -1);
        total_cnt++;
        if (pc_v[0] !== 32'h0) $display("FAIL wrap_zero got %h expected 0", pc_v[0]);
        else pass_cnt++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            step_instr(0, gen_word(1'b1), 1'($urandom), -1);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] words [3];
        logic [31:0] held;
        words = '{32'h00000000, 32'hFC000000, 32'h0109503F};
        for (int i = 0; i < 3; i++) begin
            test_reset(0);
            step_instr(0, gen_word(1'b0), 1'b0, -1);
            held = pc_v[0];
            step_instr(0, words[i], 1'b1, -1);
            total_cnt++;
            if (halted_v[0] !== 1'b1 || illegal_v[0] !== 1'b1 || retired_v[0] !== 16'd1 || pc_v[0] !== 32'd132)
                $display("FAIL illegal_halt w=%h got halt=%b ill=%b ret=%0d pc=%0d expected 1/1/1/132",
                         words[i], halted_v[0], illegal_v[0], retired_v[0], pc_v[0]);
            else pass_cnt++;
            step_instr(0, gen_word(1'b1), 1'b1, -1);
            total_cnt++;
            if (pc_v[0] !== held) $display("FAIL illegal_frozen got %h expected %h", pc_v[0], held);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_wb;
        test_reset(1);
        step_instr(1, 32'hFC000000, 1'b0, -1);
        total_cnt++;
        if (illegal_v[1] !== 1'b1 || retired_v[1] !== 16'd1 || pc_v[1] !== 32'd132)
            $display("FAIL illegal_nop got ill=%b ret=%0d pc=%0d expected 1/1/132", illegal_v[1], retired_v[1], pc_v[1]);
        else pass_cnt++;
        step_instr(1, 32'h20080005, 1'b0, 3);
        @(negedge clk);
        reset_v[1] = 1'b0;
    endtask

    task automatic test_max;
        logic [31:0] w;
        test_reset(1);
        for (int i = 0; i < 11; i++) begin
            w = ($urandom_range(0, 3) == 0) ? 32'h00000000 : gen_word(1'b0);
            step_instr(1, w, 1'($urandom), -1);
        end
        total_cnt++;
        if (halted_v[1] !== 1'b1 || retired_v[1] !== 16'd11 || pc_v[1] !== 32'd172)
            $display("FAIL max_halt got halt=%b ret=%0d pc=%0d expected 1/11/172", halted_v[1], retired_v[1], pc_v[1]);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            ins_v[1] = gen_word(1'b1);
            zero_v[1] = 1'($urandom);
            @(negedge clk);
            total_cnt++;
            if (obs(1) !== 9'h0 || pc_v[1] !== 32'd172 || halted_v[1] !== 1'b1)
                $display("FAIL halt_idle cyc%0d got ctl=%h pc=%0d halt=%b expected 0/172/1", i, obs(1), pc_v[1], halted_v[1]);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset_v = '{1'b1, 1'b1};
        ins_v   = '{32'h0, 32'h0};
        zero_v  = '{1'b0, 1'b0};
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        test_reset(0);
        test_addi();
        test_rtype();
        test_j_sw();
        test_beq();
        test_wrap();
        test_random();
        test_illegal();
        test_reset_mid_wb();
        test_max();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_seq.md
Name: mips_multicycle_seq

Overview:
- Parametrised RTL sequencer that replaces the hand-driven control loop around yIF/yID/yEX.
- Owns the PC register and a 4-state fetch/decode/execute/writeback FSM.
- Decodes the fetched instruction into datapath control signals (RegDst, RegWrite, ALUSrc, ALU op, memory strobes).
- Computes the next PC for sequential, beq and j flow. Halts after a programmable instruction count or on an illegal opcode.

Parameters:
- PC_W, 32, PC/address width (>=28).
- RESET_PC, 128, PC value loaded on reset.
- MAX_INSTR, 0, halt after this many retired instructions; 0 = unlimited.
- CNT_W, 16, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1, 1 = enter HALT on unknown opcode/funct; 0 = treat it as a NOP.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ins  in  32  instruction word from yIF at address pc.
- zero  in  1  ALU zero flag from yEX.
- pc  out  PC_W  current PC, drives yIF PCin.
- RegDst  out  1  1 = write rd, 0 = write rt.
- RegWrite  out  1  register-file write strobe.
- ALUSrc  out  1  1 = immediate operand.
- op  out  3  ALU op: 0 and, 1 or, 2 add, 6 sub, 7 slt.
- MemRead  out  1  data-memory read enable.
- MemWrite  out  1  data-memory write strobe.
- MemToReg  out  1  writeback select: memory data.
- halted  out  1  FSM is in HALT.
- illegal  out  1  sticky flag: unknown instruction seen.
- retired  out  CNT_W  count of retired instructions.

Behaviour:

Reset (async, any state, including mid-instruction):
- pc = RESET_PC; state = FETCH; IR = 0; retired = 0.
- All control outputs 0; halted = 0; illegal = 0.

States and timing (4 clocks per instruction; pc is stable for the whole instruction):
- FETCH: IR <= ins at the end of the cycle. Control outputs 0.
- DECODE: control levels are registered from IR and become valid at the start of EXEC.
- EXEC: RegDst, ALUSrc, op, MemRead and MemToReg are held. zero is sampled into zflag at the end of the cycle.
- WB: levels held. RegWrite and MemWrite are asserted for exactly this one cycle. At the end of the cycle:
  - pc <= next_pc;
  - retired <= retired + 1, saturating at all-ones;
  - go to HALT if MAX_INSTR != 0 and the new retired value == MAX_INSTR, else go to FETCH.
- HALT: absorbing until reset. All control outputs 0, pc frozen, halted = 1.

Decode on IR[31:26]; unlisted signals are 0:
- 0x00 R-type: RegDst=1, RegWrite=1, ALUSrc=0. op from funct IR[5:0]:
  - 0x20 -> 2 (add)
  - 0x22 -> 6 (sub)
  - 0x24 -> 0 (and)
  - 0x25 -> 1 (or)
  - 0x2A -> 7 (slt)
  - any other funct is illegal.
- 0x08 addi: RegWrite=1, ALUSrc=1, op=2.
- 0x23 lw: RegWrite=1, ALUSrc=1, op=2, MemRead=1, MemToReg=1.
- 0x2B sw: ALUSrc=1, op=2, MemWrite=1.
- 0x04 beq: ALUSrc=0, op=6.
- 0x02 j: no writes; op=2.
- Anything else is illegal:
  - illegal is set during DECODE, all controls forced to 0.
  - HALT_ON_ILLEGAL=1: go from DECODE straight to HALT; the instruction does not retire and pc is unchanged.
  - HALT_ON_ILLEGAL=0: proceed as a NOP and retire normally.

Next PC (modulo 2^PC_W, computed in WB):
- pcp4 = pc + 4.
- beq with zflag=1: pcp4 + (sign-extended IR[15:0] << 2).
- j: {pcp4[PC_W-1:28], IR[25:0], 2'b00}.
- Otherwise: pcp4.
- pc = 2^PC_W - 4 wraps to 0.

Boundary cases:
- Instruction word 0x00000000 is sll $0: funct 0x00 is illegal.
- ins changing outside FETCH is ignored.
- MAX_INSTR=1 halts after the first WB.
- Asserting reset in WB suppresses RegWrite and MemWrite immediately (asynchronous clear).

Test Plan:
- Reset then release; ins=0x20080005 (addi) -> pc=128 throughout FETCH..WB. RegWrite=1 only in cycle 4, ALUSrc=1, op=2. pc=132 and retired=1 after WB.
- R-type sub, ins=0x01095022 -> RegDst=1, ALUSrc=0, op=6, RegWrite pulsed once. Repeat with funct 0x2A -> op=7.
- beq ins=0x1109FFFE at pc=200, zero=1 in EXEC -> next pc=196. Same with zero=0 -> next pc=204.
- j ins=0x08000040 at pc=0x80 -> next pc=0x100. Then sw 0xAD090004 -> MemWrite=1 in WB only, RegWrite=0.
- MAX_INSTR=11 with a straight-line program -> halted=1 after exactly 44 clocks, retired=11, pc=128+44. All strobes stay 0 afterwards for 20 further clocks.
- Opcode 0x3F with HALT_ON_ILLEGAL=1 -> illegal=1, halted=1 after DECODE, retired unchanged, no strobes. Reset asserted mid-WB -> RegWrite drops the same timestep, pc=128, illegal=0.
